// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Desc     : Direct-mapped, one-word-per-line instruction cache. Define ICACHE_EN
//            to build the tag/data arrays; without it every fetch goes to memory.
// Revision : 1.0 - initial release
// ============================================================================
module icache #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        _clear,
   input  logic        _fetch_req,
   input  logic [31:0] _fetch_pc,
   output logic        _busy,
   output logic        _inst_ready_out,
   output logic [31:0] _inst_out,
   output logic        _mem_req,
   output logic [31:0] _mem_addr,
   input  logic        _mem_done,
   input  logic [31:0] _mem_data
);

   localparam int c_lines = 2**INDEX_BITS;
   localparam int c_tag_w = 30 - INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MISS  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e      state_q;
   logic        busy_q;
   logic        ready_q;
   logic        mem_req_q;
   logic [31:0] inst_q;
   logic [31:0] mem_addr_q;

   logic        w_hit;
   logic [31:0] w_hit_data;
   logic        w_fill;
   logic [1:0]  w_unused_bits;

   assign w_unused_bits = _fetch_pc[1:0];
   // A reply is only absorbed while a miss (live or cancelled) is outstanding.
   assign w_fill        = rdy_in && _mem_done && (state_q != S_IDLE);

`ifdef ICACHE_EN
   logic [INDEX_BITS-1:0] w_req_idx;
   logic [INDEX_BITS-1:0] w_fill_idx;
   logic [c_tag_w-1:0]    w_req_tag;
   logic [c_tag_w-1:0]    w_fill_tag;
   logic [c_lines-1:0]    valid_q;
   logic [c_tag_w-1:0]    tag_q  [c_lines];
   logic [31:0]           data_q [c_lines];

   assign w_req_idx  = _fetch_pc[INDEX_BITS+1:2];
   assign w_req_tag  = _fetch_pc[31:INDEX_BITS+2];
   assign w_fill_idx = mem_addr_q[INDEX_BITS+1:2];
   assign w_fill_tag = mem_addr_q[31:INDEX_BITS+2];
   assign w_hit      = valid_q[w_req_idx] && (tag_q[w_req_idx] == w_req_tag);
   assign w_hit_data = data_q[w_req_idx];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_q <= '0;
      end else if (w_fill) begin
         valid_q[w_fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_fill) begin
         tag_q[w_fill_idx]  <= w_fill_tag;
         data_q[w_fill_idx] <= _mem_data;
      end
   end
`else
   assign w_hit      = 1'b0;
   assign w_hit_data = '0;
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         mem_req_q  <= 1'b0;
         inst_q     <= '0;
         mem_addr_q <= '0;
      end else if (rdy_in) begin
         ready_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (_fetch_req && !_clear) begin
                  if (w_hit) begin
                     ready_q <= 1'b1;
                     inst_q  <= w_hit_data;
                  end else begin
                     mem_req_q  <= 1'b1;
                     mem_addr_q <= {_fetch_pc[31:2], 2'b00};
                     busy_q     <= 1'b1;
                     state_q    <= S_MISS;
                  end
               end
            end
            S_MISS: begin
               if (_mem_done) begin
                  mem_req_q <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
                  if (!_clear) begin
                     ready_q <= 1'b1;
                     inst_q  <= _mem_data;
                  end
               end else if (_clear) begin
                  // The memory request is kept alive; only delivery is cancelled.
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (_mem_done) begin
                  mem_req_q <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign _busy           = busy_q;
   assign _inst_ready_out = ready_q;
   assign _inst_out       = inst_q;
   assign _mem_req        = mem_req_q;
   assign _mem_addr       = mem_addr_q;

endmodule
`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache between the memory controller and the instruction fetcher. It accepts one fetch request at a time (PC plus request strobe) and returns the 32-bit instruction word with a one-cycle ready pulse. Hits are served from local arrays; misses issue a single-word read to the memory controller. A pipeline `_clear` (branch mispredict) cancels delivery of any outstanding fetch.

## Interface
Parameters:
- `INDEX_BITS`, default 6: line-index width; the cache holds 2^INDEX_BITS lines of one 32-bit word each.

Ports:
- `clk_in` in 1: system clock; the only clock.
- `rst_in` in 1: synchronous, active-high reset.
- `rdy_in` in 1: global ready; when low, all state and outputs freeze.
- `_clear` in 1: pipeline flush; cancels pending or outstanding fetch delivery.
- `_fetch_req` in 1: fetcher requests the instruction at `_fetch_pc`; sampled only when `_busy` is low.
- `_fetch_pc` in 32: fetch address; bits [1:0] ignored.
- `_busy` out 1: high while a miss is outstanding; the fetcher must not request while high.
- `_inst_ready_out` out 1: one-cycle pulse; `_inst_out` is valid.
- `_inst_out` out 32: instruction word.
- `_mem_req` out 1: word-read request to the memory controller; level signal.
- `_mem_addr` out 32: `{pc[31:2], 2'b00}`; stable while `_mem_req` is high.
- `_mem_done` in 1: one-cycle pulse from the memory controller; `_mem_data` is valid.
- `_mem_data` in 32: returned word.

## Operation
- Address split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[31:INDEX_BITS+2]
  - each line holds a valid bit, a tag and a data word.
- States:
  - IDLE: no miss outstanding.
  - MISS: waiting for memory on behalf of a live fetch.
  - DRAIN: miss cancelled by `_clear`; waiting to absorb the memory reply.
- IDLE, `_fetch_req` high, `_clear` low:
  - Hit: next cycle `_inst_ready_out`=1 and `_inst_out`=line data. Stay in IDLE.
  - Miss: next cycle `_mem_req`=1, `_mem_addr` is latched, `_busy`=1. Go to MISS.
- MISS, `_mem_done`:
  - Write the line (valid=1, tag, data) and clear `_mem_req`.
  - Next cycle `_inst_ready_out`=1 and `_inst_out`=`_mem_data`. Go to IDLE.
- MISS, `_clear` without `_mem_done`: go to DRAIN. `_mem_req` stays high until `_mem_done`; the controller request is never abandoned.
- DRAIN, `_mem_done`: write the line, produce no output, go to IDLE.
- `_clear` and `_mem_done` in the same cycle (MISS): write the line, produce no output, go to IDLE.
- `_clear` in IDLE:
  - The same-cycle `_fetch_req` is ignored.
  - A hit pulse scheduled for the next cycle is suppressed.
- `_fetch_req` while `_busy` is high is ignored; it is not queued.
- Reset:
  - All valid bits are cleared; state goes to IDLE.
  - Reset values: `_busy`=0, `_inst_ready_out`=0, `_inst_out`=0, `_mem_req`=0, `_mem_addr`=0.
  - Reset mid-miss abandons the miss; the memory controller shares `rst_in`.
- `rdy_in` low has no effect on state, arrays or outputs. `_mem_done` arriving while `rdy_in` is low is a controller protocol violation and is not handled.

## Timing
- Hit latency: 1 cycle (request cycle N, ready pulse cycle N+1).
- Miss latency: `_mem_req` rises at N+1; the ready pulse comes one cycle after `_mem_done`.
- Back-to-back hits: one request per cycle is accepted in IDLE.
- `_busy` is registered:
  - rises the cycle after a miss is detected;
  - falls in the cycle following `_mem_done`.
- `_inst_ready_out` never stays high for more than 1 cycle per request.

## Configuration
- `ICACHE_EN` defined: tag and data arrays are built and hits are served locally as above.
- `ICACHE_EN` undefined:
  - No arrays are built; every request takes the miss path.
  - Port behaviour, `_clear`/DRAIN handling and reset values are identical; only latency differs.

## Test plan
- Reset, then fetch pc=0x0000_0000 → `_mem_req`=1 and `_mem_addr`=0x0 one cycle later. `_mem_done` with data 0x0000_0013 → one cycle later `_inst_ready_out`=1 and `_inst_out`=0x0000_0013. `_busy` is 0 in that cycle.
- Refetch pc=0x0 → ready 1 cycle later with 0x0000_0013 and no `_mem_req` (with `ICACHE_EN`).
- Conflict: fetch 0x0000_0100 (same index when INDEX_BITS=6, different tag) → miss. Then 0x0 → miss again.
- Miss on 0x0000_0004, assert `_clear` before `_mem_done` → `_mem_req` stays high. `_mem_done` brings no `_inst_ready_out`; refetch 0x4 then hits.
- Hit request with `_clear` in the same cycle → no ready pulse. `rdy_in` low for 3 cycles mid-miss → `_mem_req` and state are held.
- Reset asserted in MISS → next cycle `_busy`=0 and `_mem_req`=0; a refetch of a previously cached pc misses.
